// File: rtl/sincronizador_if.sv
// Code-group stream into the 1000BASE-X receive sync stage, plus the
// registered code-group and status flags coming back out of it.
interface sincronizador_if;
  logic       signal_detect;
  logic [9:0] rx_code_group;
  logic [9:0] rx_code_group_out;
  logic       sync_status;
  logic       rx_even;
  logic       cg_invalid;

  modport master (
    output signal_detect, rx_code_group,
    input  rx_code_group_out, sync_status, rx_even, cg_invalid
  );

  modport slave (
    input  signal_detect, rx_code_group,
    output rx_code_group_out, sync_status, rx_even, cg_invalid
  );
endinterface

// File: rtl/sincronizador.sv
// 1000BASE-X PCS receive synchronization: code-group validity, running
// disparity, even/odd alignment and the loss/acquire/hold sync state machine.
module sincronizador #(
  parameter int GOOD_CGS_MAX = 3
) (
  input  logic         GTX_CLK,
  input  logic         RESET,
  sincronizador_if.slave bus
);
  localparam int CNT_W = $clog2(GOOD_CGS_MAX + 1);

  typedef enum logic [3:0] {
    LOSS_OF_SYNC, COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3,
    ACQUIRE_SYNC_1, ACQUIRE_SYNC_2, ACQUIRE_SYNC_3,
    SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
    SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] good_cnt_q;
  logic             rd_q;            // 1 = RD+, 0 = RD-
  logic             rx_even_q;
  logic             sync_status_q;
  logic             cg_invalid_q;
  logic [9:0]       cg_out_q;

  function automatic logic [3:0] ones_of(input logic [9:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 10; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  logic [5:0] cg6;
  logic [3:0] cg4;
  logic [3:0] ones6, ones4, ones_all;
  logic       struct_ok, pos6, neg6, pos4, neg4;
  logic       rd_mid, rd_err6, rd_err4, rd_d;
  logic       invalid, comma, is_k, is_data, cgbad;

  assign cg6      = bus.rx_code_group[9:4];
  assign cg4      = bus.rx_code_group[3:0];
  assign ones6    = ones_of({4'b0000, cg6});
  assign ones4    = ones_of({6'b000000, cg4});
  assign ones_all = ones6 + ones4;

  assign struct_ok = (ones_all >= 4'd4) && (ones_all <= 4'd6) &&
                     (ones6 >= 4'd2) && (ones6 <= 4'd4) &&
                     (ones4 >= 4'd1) && (ones4 <= 4'd3) &&
                     (cg6 != 6'b000000) && (cg6 != 6'b111111) &&
                     (cg4 != 4'b0000) && (cg4 != 4'b1111);

  // Balanced-count exceptions 000111/111000 and 0011/1100 carry disparity.
  assign pos6 = (ones6 > 4'd3) || (cg6 == 6'b000111);
  assign neg6 = (ones6 < 4'd3) || (cg6 == 6'b111000);
  assign pos4 = (ones4 > 4'd2) || (cg4 == 4'b0011);
  assign neg4 = (ones4 < 4'd2) || (cg4 == 4'b1100);

  assign rd_err6 = (pos6 && rd_q) || (neg6 && !rd_q);
  assign rd_mid  = rd_q ^ (pos6 | neg6);
  assign rd_err4 = (pos4 && rd_mid) || (neg4 && !rd_mid);
  assign rd_d    = rd_mid ^ (pos4 | neg4);

  assign invalid = !struct_ok || rd_err6 || rd_err4;
  assign comma   = (bus.rx_code_group[9:3] == 7'b0011111) ||
                   (bus.rx_code_group[9:3] == 7'b1100000);
  assign is_k    = (cg6 == 6'b001111) || (cg6 == 6'b110000) ||
                   (bus.rx_code_group == 10'b1110101000) || (bus.rx_code_group == 10'b0001010111) ||
                   (bus.rx_code_group == 10'b1101101000) || (bus.rx_code_group == 10'b0010010111) ||
                   (bus.rx_code_group == 10'b1011101000) || (bus.rx_code_group == 10'b0100010111) ||
                   (bus.rx_code_group == 10'b0111101000) || (bus.rx_code_group == 10'b1000010111);
  assign is_data = !invalid && !is_k;
  // A comma after an even code-group would itself sit on an odd position.
  assign cgbad   = invalid || (comma && rx_even_q);

  always_ff @(posedge GTX_CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= LOSS_OF_SYNC;
      good_cnt_q    <= '0;
      rd_q          <= 1'b0;
      rx_even_q     <= 1'b0;
      sync_status_q <= 1'b0;
      cg_invalid_q  <= 1'b0;
      cg_out_q      <= '0;
    end else begin
      cg_out_q      <= bus.rx_code_group;
      cg_invalid_q  <= invalid;
      rd_q          <= rd_d;
      rx_even_q     <= !rx_even_q;
      sync_status_q <= 1'b0;
      if (!bus.signal_detect) begin
        state_q <= LOSS_OF_SYNC;
      end else begin
        case (state_q)
          LOSS_OF_SYNC:
            if (comma) begin state_q <= COMMA_DETECT_1; rx_even_q <= 1'b1; end
          COMMA_DETECT_1:
            state_q <= is_data ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
          COMMA_DETECT_2:
            state_q <= is_data ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
          COMMA_DETECT_3:
            if (is_data) begin state_q <= SYNC_ACQUIRED_1; sync_status_q <= 1'b1; end
            else state_q <= LOSS_OF_SYNC;
          ACQUIRE_SYNC_1, ACQUIRE_SYNC_2, ACQUIRE_SYNC_3:
            if (cgbad) state_q <= LOSS_OF_SYNC;
            else if (comma && !rx_even_q) begin
              rx_even_q <= 1'b1;
              state_q   <= (state_q == ACQUIRE_SYNC_1) ? COMMA_DETECT_2 : COMMA_DETECT_3;
            end
          SYNC_ACQUIRED_1: begin
            sync_status_q <= 1'b1;
            if (cgbad) begin state_q <= SYNC_ACQUIRED_2; good_cnt_q <= '0; end
          end
          SYNC_ACQUIRED_2: begin
            sync_status_q <= 1'b1;
            if (cgbad) begin state_q <= SYNC_ACQUIRED_3; good_cnt_q <= '0; end
            else begin state_q <= SYNC_ACQUIRED_2A; good_cnt_q <= good_cnt_q + 1'b1; end
          end
          SYNC_ACQUIRED_3: begin
            sync_status_q <= 1'b1;
            if (cgbad) begin state_q <= SYNC_ACQUIRED_4; good_cnt_q <= '0; end
            else begin state_q <= SYNC_ACQUIRED_3A; good_cnt_q <= good_cnt_q + 1'b1; end
          end
          SYNC_ACQUIRED_4:
            if (cgbad) state_q <= LOSS_OF_SYNC;
            else begin
              sync_status_q <= 1'b1;
              state_q       <= SYNC_ACQUIRED_4A;
              good_cnt_q    <= good_cnt_q + 1'b1;
            end
          SYNC_ACQUIRED_2A: begin
            sync_status_q <= 1'b1;
            if (cgbad) begin state_q <= SYNC_ACQUIRED_3; good_cnt_q <= '0; end
            else if (good_cnt_q == CNT_W'(GOOD_CGS_MAX)) state_q <= SYNC_ACQUIRED_1;
            else good_cnt_q <= good_cnt_q + 1'b1;
          end
          SYNC_ACQUIRED_3A: begin
            sync_status_q <= 1'b1;
            if (cgbad) begin state_q <= SYNC_ACQUIRED_4; good_cnt_q <= '0; end
            else if (good_cnt_q == CNT_W'(GOOD_CGS_MAX)) begin
              state_q <= SYNC_ACQUIRED_2; good_cnt_q <= '0;
            end else good_cnt_q <= good_cnt_q + 1'b1;
          end
          SYNC_ACQUIRED_4A:
            if (cgbad) state_q <= LOSS_OF_SYNC;
            else begin
              sync_status_q <= 1'b1;
              if (good_cnt_q == CNT_W'(GOOD_CGS_MAX)) begin
                state_q <= SYNC_ACQUIRED_3; good_cnt_q <= '0;
              end else good_cnt_q <= good_cnt_q + 1'b1;
            end
          default: state_q <= LOSS_OF_SYNC;
        endcase
      end
    end
  end

  assign bus.rx_code_group_out = cg_out_q;
  assign bus.sync_status       = sync_status_q;
  assign bus.rx_even           = rx_even_q;
  assign bus.cg_invalid        = cg_invalid_q;
endmodule

// File: tb/tb_sincronizador.sv
// Directed bench for sincronizador: reset, /I2/ acquisition, error tolerance,
// loss of sync, misaligned comma, disparity error, signal loss, async reset.
module tb_sincronizador;
  localparam logic [9:0] K_N  = 10'b0011111010;  // K28.5 RD-
  localparam logic [9:0] K_P  = 10'b1100000101;  // K28.5 RD+
  localparam logic [9:0] D_N  = 10'b0110110101;  // D16.2 RD-
  localparam logic [9:0] D_P  = 10'b1001000101;  // D16.2 RD+
  localparam logic [9:0] BAD  = 10'b0000000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   rd_pos = 1'b0;

  sincronizador_if bus();

  sincronizador #(.GOOD_CGS_MAX(3)) dut (
    .GTX_CLK (clk),
    .RESET   (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [9:0] cg);
    bus.rx_code_group = cg;
    @(posedge clk);
    #1;
    $display("cg=%b out=%b sync=%0d even=%0d inv=%0d", cg, bus.rx_code_group_out,
             bus.sync_status, bus.rx_even, bus.cg_invalid);
  endtask

  // Transmitter-side disparity choice: K28.5 and D16.2 both flip RD.
  task automatic send_k();
    logic [9:0] cg;
    cg = rd_pos ? K_P : K_N;
    rd_pos = ~rd_pos;
    step(cg);
  endtask

  task automatic send_d();
    logic [9:0] cg;
    cg = rd_pos ? D_P : D_N;
    rd_pos = ~rd_pos;
    step(cg);
  endtask

  task automatic acquire();
    repeat (3) begin send_k(); send_d(); end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.signal_detect = 1'b1;
    bus.rx_code_group = '0;
    rd_pos = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.signal_detect = 1'b1;
    bus.rx_code_group = '0;

    // Reset and idle
    do_reset();
    chk("rst_sync", bus.sync_status, 0);
    chk("rst_even", bus.rx_even, 0);
    chk("rst_inv", bus.cg_invalid, 0);
    chk("rst_out", bus.rx_code_group_out, 0);
    step(BAD);
    chk("idle_sync", bus.sync_status, 0);
    chk("idle_even", bus.rx_even, 1);
    chk("idle_inv", bus.cg_invalid, 1);
    step(BAD);
    chk("idle_sync2", bus.sync_status, 0);

    // Acquisition: sync rises on the sixth code-group
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) send_k(); else send_d();
      chk("acq_even", bus.rx_even, 10'((i % 2) == 0));
      chk("acq_inv", bus.cg_invalid, 0);
      chk("acq_sync", bus.sync_status, 10'(i == 5));
      if (i == 0) chk("acq_out", bus.rx_code_group_out, K_N);
    end

    // Error tolerance: one bad code-group replaces a D, then four good ones
    send_k();
    step(BAD);
    chk("tol_inv", bus.cg_invalid, 1);
    chk("tol_sync", bus.sync_status, 1);
    chk("tol_out", bus.rx_code_group_out, BAD);
    send_k();
    chk("tol_inv_clr", bus.cg_invalid, 0);
    chk("tol_even", bus.rx_even, 1);
    send_d(); send_k(); send_d();
    chk("tol_sync2", bus.sync_status, 1);

    // Back in SYNC_ACQUIRED_1: three bad keep sync, the fourth drops it
    step(BAD); step(BAD); step(BAD);
    chk("los_sync3", bus.sync_status, 1);
    step(BAD);
    chk("los_sync4", bus.sync_status, 0);

    // Misaligned comma lands in SYNC_ACQUIRED_2
    do_reset();
    acquire();
    send_k(); send_d(); send_d();
    chk("mis_even_d", bus.rx_even, 1);
    send_k();
    chk("mis_inv", bus.cg_invalid, 0);
    chk("mis_sync", bus.sync_status, 1);
    chk("mis_even_k", bus.rx_even, 0);
    step(BAD); step(BAD);
    chk("mis_sync_sa4", bus.sync_status, 1);
    step(BAD);
    chk("mis_sync_lost", bus.sync_status, 0);

    // Disparity error: K28.5 RD- twice
    do_reset();
    step(K_N);
    chk("rd_first", bus.cg_invalid, 0);
    step(K_N);
    chk("rd_second", bus.cg_invalid, 1);

    // Signal loss mid-sync
    do_reset();
    acquire();
    send_k();
    chk("sd_sync_before", bus.sync_status, 1);
    bus.signal_detect = 1'b0;
    send_d();
    chk("sd_sync_after", bus.sync_status, 0);
    bus.signal_detect = 1'b1;

    // Asynchronous reset mid-stream, checked before the next edge
    do_reset();
    acquire();
    chk("ar_sync_before", bus.sync_status, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_sync", bus.sync_status, 0);
    chk("ar_even", bus.rx_even, 0);
    chk("ar_inv", bus.cg_invalid, 0);
    chk("ar_out", bus.rx_code_group_out, 0);
    #2;
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
